ibex_cheri_fetch_queue: RTL
===========================

// Module: ibex_cheri_fetch_queue
// PURPOSE
//  Parametrised capability-aware instruction prefetch queue sitting between the IF stage and instr memory.
//  Issues word fetches ahead of execution, tracks up to MaxOutstanding in-flight requests,
//  buffers Depth returned words and discards stale responses after a branch.
//  Optionally checks each fetch word against PCC bounds and queues a fault entry instead of fetching.
// PARAMETERS
//  Depth          3             FIFO entries (>=2)
//  MaxOutstanding 2             max granted-but-unanswered requests (1..Depth)
//  BootAddr       32'h00000080  fetch address after reset (word aligned)
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   reset, asynchronous, active-high
//  req_i           in   1   fetching enabled
//  branch_i        in   1   redirect fetch, flush queue
//  branch_addr_i   in   32  redirect target; bits[1:0] ignored
//  pcc_base_i      in   32  decoded PCC base
//  pcc_top_i       in   33  decoded PCC top (exclusive, 2^32 allowed)
//  valid_o         out  1   head entry valid
//  ready_i         in   1   consumer accepts head
//  rdata_o         out  32  head instruction word
//  addr_o          out  32  head word address (bits[1:0]=0)
//  fault_o         out  1   head entry is a PCC bounds fault
//  instr_req_o     out  1   bus request
//  instr_addr_o    out  32  bus word address
//  instr_gnt_i     in   1   bus grant
//  instr_rvalid_i  in   1   bus response valid (in order)
//  instr_rdata_i   in   32  bus response data
//  busy_o          out  1   outstanding != 0
// BEHAVIOUR
//  - Reset: valid_o=0, instr_req_o=0, busy_o=0, fault_o=0, rdata_o/addr_o=0, count=0, outstanding=0, discard=0, fetch_addr=BootAddr, stalled=0.
//  - Issue: instr_req_o = req_i & !branch_i & !stalled & in_bounds & outstanding<MaxOutstanding & count+outstanding<Depth.
//    instr_addr_o=fetch_addr. On req&gnt: outstanding++, fetch_addr+=4 (wraps mod 2^32).
//  - Response: rvalid decrements outstanding. If discard>0: drop word, discard--; else push {rdata, addr, fault=0}.
//    Reservation rule guarantees push never overflows; rvalid with outstanding==0 is a bus error (assertion).
//  - Pop: valid_o&ready_i removes head. Push and pop in the same cycle keep count unchanged.
//    Empty queue: no bypass; latency rvalid->valid_o is 1 cycle.
//  - Branch (highest priority): count:=0, fetch_addr:={branch_addr_i[31:2],2'b00}, stalled:=0,
//    discard := outstanding - rvalid (the response in the branch cycle is dropped). instr_req_o low in the branch cycle.
//    First new request no earlier than the next cycle.
//  - Branch while discard>0: discard is recomputed from outstanding (old residue included), never summed.
//  - Order preserved: entries leave in fetch-address order; a fault entry is never overtaken by older data.
//  - fetch_addr wrap 32'hFFFFFFFC -> 0 is legal; the bounds check uses the 33-bit sum.
// CONFIGURATION
//  IBEX_FETCH_BOUNDS_CHECK_EN defined:
//    in_bounds = (fetch_addr >= pcc_base_i) & ({1'b0,fetch_addr}+4 <= pcc_top_i).
//    If !in_bounds & req_i & outstanding==0 & count<Depth: push {rdata=0, addr=fetch_addr, fault=1}, stalled:=1.
//    No bus request is made for that word. stalled blocks issue until branch_i.
//  IBEX_FETCH_BOUNDS_CHECK_EN undefined:
//    in_bounds=1, fault_o tied 0, stalled constant 0, pcc_* inputs unused (lint waiver).
// STRUCTURE
//  ibex_cheri_pkg: typedef struct packed {logic [31:0] rdata; logic [31:0] addr; logic fault;} fetch_entry_t;
//    also FETCH_WORD_BYTES=4.
//  Sub-module ibex_cheri_fetch_fifo #(Depth):
//    flop-array FIFO of fetch_entry_t with push/pop/flush, count output, head output.
//  Top level holds the outstanding/discard counters, fetch_addr, stalled and the bounds check.
// TESTING
//  1 Reset release, req_i=1, gnt every cycle, rvalid 1 cycle later:
//    addresses 0x80,0x84,0x88; valid_o follows rvalid by 1 cycle with matching addr_o.
//  2 ready_i=0 with Depth=3, MaxOutstanding=2:
//    after 3 words queued, instr_req_o stays 0; one pop re-enables exactly one request.
//  3 Branch to 0x1002 with 2 outstanding and rvalid in the branch cycle:
//    that word and the next are dropped; the first queued addr_o is 0x1000.
//  4 gnt held low 5 cycles: instr_req_o and instr_addr_o stay stable until gnt; no entry pushed.
//  5 [BOUNDS_CHECK_EN] base=0x100, top=0x108, branch to 0x100:
//    fetches 0x100 and 0x104, then fault entry addr 0x108 fault_o=1.
//    No request for 0x108 until branch_i.
//  6 Async rst_i mid-burst, asserted between clock edges:
//    valid_o, instr_req_o and busy_o drop immediately; fetch restarts at BootAddr.

Source files
------------

// File: rtl/ibex_cheri_pkg.sv
// Shared types for the capability-aware instruction fetch queue.
package ibex_cheri_pkg;

  localparam int unsigned FETCH_WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/ibex_cheri_fetch_queue_if.sv
// Consumer and instruction-bus signals of the fetch queue.
// master = the fetch queue, slave = the IF stage / memory side that drives it.
interface ibex_cheri_fetch_queue_if;

  logic        req;
  logic        branch;
  logic [31:0] branch_addr;
  logic [31:0] pcc_base;
  logic [32:0] pcc_top;

  logic        valid;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic        fault;

  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;

  logic        busy;

  modport master (
    input  req, branch, branch_addr, pcc_base, pcc_top, ready,
           instr_gnt, instr_rvalid, instr_rdata,
    output valid, rdata, addr, fault, instr_req, instr_addr, busy
  );

  modport slave (
    output req, branch, branch_addr, pcc_base, pcc_top, ready,
           instr_gnt, instr_rvalid, instr_rdata,
    input  valid, rdata, addr, fault, instr_req, instr_addr, busy
  );

endinterface

// File: rtl/ibex_cheri_fetch_fifo.sv
// Flop-array FIFO of fetch entries; flush wins over push and pop in the same cycle.
module ibex_cheri_fetch_fifo
  import ibex_cheri_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output fetch_entry_t                 head_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ibex_cheri_fetch_queue.sv
// Capability-aware instruction prefetch queue between IF stage and instruction memory.
// Define IBEX_FETCH_BOUNDS_CHECK_EN to check each fetch word against PCC bounds.
module ibex_cheri_fetch_queue
  import ibex_cheri_pkg::*;
#(
  parameter int unsigned Depth          = 3,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] BootAddr       = 32'h0000_0080
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ibex_cheri_fetch_queue_if.master bus
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [CntW-1:0] count;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW:0]   reserved;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     resp_addr_q, resp_addr_d;
  logic            issue, fire, pop, push, resp_keep;
  logic            in_bounds, fault_push, stalled_q;
  fetch_entry_t    head, push_entry;

  // Every in-flight request owns a queue slot, so a response can never overflow.
  assign reserved = {1'b0, count} + {1'b0, outstanding_q};

  assign issue = ~rst_i & bus.req & ~bus.branch & ~stalled_q & in_bounds
               & (outstanding_q < CntW'(MaxOutstanding))
               & (reserved < (CntW+1)'(Depth));
  assign fire  = issue & bus.instr_gnt;

  assign resp_keep = bus.instr_rvalid & (discard_q == '0);
  assign push      = fault_push | resp_keep;
  assign pop       = bus.valid & bus.ready;

`ifdef IBEX_FETCH_BOUNDS_CHECK_EN
  logic [32:0] fetch_end;

  // 33-bit sum so a word ending exactly at 2^32 is still in bounds.
  assign fetch_end  = {1'b0, fetch_addr_q} + 33'(FETCH_WORD_BYTES);
  assign in_bounds  = (fetch_addr_q >= bus.pcc_base) & (fetch_end <= bus.pcc_top);
  assign fault_push = ~rst_i & bus.req & ~bus.branch & ~stalled_q & ~in_bounds
                    & (outstanding_q == '0) & (count < CntW'(Depth));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stalled_q <= 1'b0;
    end else if (bus.branch) begin
      stalled_q <= 1'b0;
    end else if (fault_push) begin
      stalled_q <= 1'b1;
    end
  end

  assign bus.fault = head.fault;
`else
  logic unused_bounds;

  assign unused_bounds = ^{bus.pcc_base, bus.pcc_top, head.fault};
  assign in_bounds     = 1'b1;
  assign fault_push    = 1'b0;
  assign stalled_q     = 1'b0;
  assign bus.fault     = 1'b0;
`endif

  always_comb begin
    push_entry       = '0;
    push_entry.rdata = bus.instr_rdata;
    push_entry.addr  = resp_addr_q;
    push_entry.fault = 1'b0;
    if (fault_push) begin
      push_entry.rdata = '0;
      push_entry.addr  = fetch_addr_q;
      push_entry.fault = 1'b1;
    end
  end

  ibex_cheri_fetch_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bus.branch),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  // A branch discards everything still in flight, including any earlier residue.
  always_comb begin
    outstanding_d = outstanding_q + CntW'(fire) - CntW'(bus.instr_rvalid);
    discard_d     = discard_q;
    fetch_addr_d  = fetch_addr_q;
    resp_addr_d   = resp_addr_q;
    if (bus.branch) begin
      discard_d    = outstanding_q - CntW'(bus.instr_rvalid);
      fetch_addr_d = {bus.branch_addr[31:2], 2'b00};
      resp_addr_d  = {bus.branch_addr[31:2], 2'b00};
    end else begin
      if (bus.instr_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CntW'(1);
      end
      if (resp_keep) begin
        resp_addr_d = resp_addr_q + 32'(FETCH_WORD_BYTES);
      end
      if (fire) begin
        fetch_addr_d = fetch_addr_q + 32'(FETCH_WORD_BYTES);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= BootAddr;
      resp_addr_q   <= BootAddr;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
    end
  end

  assign bus.valid      = (count != '0);
  assign bus.rdata      = head.rdata;
  assign bus.addr       = head.addr;
  assign bus.instr_req  = issue;
  assign bus.instr_addr = fetch_addr_q;
  assign bus.busy       = (outstanding_q != '0);

  // The bus returns responses only for granted requests.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.instr_rvalid && (outstanding_q == '0)));

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && !bus.branch && (count == CntW'(Depth))));

endmodule
